// File: rtl/cache_fill_ctrl_if.sv
// Miss/fill bus between the I/D cache tops, main memory and cache_fill_ctrl.
// The master modport is the controller side; the slave modport is the caches/memory side.
interface cache_fill_ctrl_if #(parameter int ADDR_W = 16);
  logic              icache_miss;
  logic [ADDR_W-1:0] icache_addr;
  logic              dcache_miss;
  logic [ADDR_W-1:0] dcache_addr;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_data_valid;
  logic [15:0]       mem_data;
  logic              icache_fill_en;
  logic              dcache_fill_en;
  logic [1:0]        fill_op;
  logic [ADDR_W-1:0] fill_addr;
  logic [15:0]       fill_data;
  logic              busy;

  modport master (
    input  icache_miss, icache_addr, dcache_miss, dcache_addr, mem_data_valid, mem_data,
    output mem_en, mem_addr, icache_fill_en, dcache_fill_en, fill_op, fill_addr, fill_data, busy
  );

  modport slave (
    output icache_miss, icache_addr, dcache_miss, dcache_addr, mem_data_valid, mem_data,
    input  mem_en, mem_addr, icache_fill_en, dcache_fill_en, fill_op, fill_addr, fill_data, busy
  );
endinterface

// File: rtl/cache_fill_ctrl.sv
// Cache miss fill controller: arbitrates I/D misses, streams one block from main memory,
// fills it word by word and commits the tag. Define CACHE_ARB_RR_EN for round-robin arbitration.
//
//  state  | meaning
//  IDLE   | no fill; sample misses, latch requester and block base
//  ISSUE  | one memory read per cycle, words 0..WORDS-1; returns written as they arrive
//  DRAIN  | all reads issued, waiting for the remaining returns
//  COMMIT | one-cycle tag/LRU commit to the granted cache
module cache_fill_ctrl #(
  parameter int ADDR_W = 16,
  parameter int WORDS  = 8
) (
  input logic              clk,
  input logic              rst,
  cache_fill_ctrl_if.master bus
);

  localparam int CNT_W = $clog2(WORDS);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(2 * WORDS - 1);
  localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, COMMIT} state_t;

  state_t            state;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  rcv_cnt;
  logic              rcv_done;
  logic              grant_d;
  logic [ADDR_W-1:0] base;

  logic take;
  logic last_rcv;
  logic commit;
  logic pick_d;

  // Returns are only accepted while a fill is streaming and the block is not yet complete.
  assign take     = (state == ISSUE || state == DRAIN) && !rcv_done && bus.mem_data_valid;
  assign last_rcv = take && (rcv_cnt == LAST_WORD);
  assign commit   = (state == COMMIT);

`ifdef CACHE_ARB_RR_EN
  logic last_d;
  assign pick_d = bus.dcache_miss && (!bus.icache_miss || !last_d);
`else
  assign pick_d = bus.dcache_miss;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      issue_cnt <= '0;
      rcv_cnt   <= '0;
      rcv_done  <= 1'b0;
      grant_d   <= 1'b0;
      base      <= '0;
`ifdef CACHE_ARB_RR_EN
      last_d    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.dcache_miss || bus.icache_miss) begin
            grant_d   <= pick_d;
            base      <= (pick_d ? bus.dcache_addr : bus.icache_addr) & ~OFF_MASK;
            issue_cnt <= '0;
            rcv_cnt   <= '0;
            rcv_done  <= 1'b0;
            state     <= ISSUE;
`ifdef CACHE_ARB_RR_EN
            // Rotation only advances on a real conflict.
            if (bus.dcache_miss && bus.icache_miss) last_d <= pick_d;
`endif
          end
        end
        ISSUE: begin
          issue_cnt <= issue_cnt + 1'b1;
          if (issue_cnt == LAST_WORD) state <= (rcv_done || last_rcv) ? COMMIT : DRAIN;
        end
        DRAIN: begin
          if (last_rcv) state <= COMMIT;
        end
        COMMIT: state <= IDLE;
        default: state <= IDLE;
      endcase

      if (take) begin
        rcv_cnt <= rcv_cnt + 1'b1;
        if (last_rcv) rcv_done <= 1'b1;
      end
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.mem_en   = (state == ISSUE);
  assign bus.mem_addr = bus.mem_en ? (base | ADDR_W'({issue_cnt, 1'b0})) : '0;

  assign bus.fill_op   = commit ? 2'b10 : (take ? 2'b01 : 2'b00);
  assign bus.fill_addr = commit ? base : (take ? (base | ADDR_W'({rcv_cnt, 1'b0})) : '0);
  assign bus.fill_data = take ? bus.mem_data : 16'h0000;

  assign bus.dcache_fill_en = (commit || take) && grant_d;
  assign bus.icache_fill_en = (commit || take) && !grant_d;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Self-checking bench for cache_fill_ctrl: pipelined memory model, cycle-level reference model,
// table-driven miss vectors, directed corner sequences and a randomized phase.
module tb_cache_fill_ctrl;
  localparam int MEM_LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cache_fill_ctrl_if #(.ADDR_W(16)) bus ();
  cache_fill_ctrl #(.ADDR_W(16), .WORDS(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // memory: in-order request queue, each word ready MEM_LAT cycles after its issue cycle
  typedef struct { logic [15:0] addr; int ready; } req_t;
  req_t memq[$];
  bit   gap_mode = 0, rand_gap = 0, stale_rand = 0, stale_force = 0;
  int   ret_budget = -1;
  int   gap_idx = 0;
  int   gap_pat[5] = '{1, 0, 1, 1, 0};

  // reference model: one block = 8 issues, 8 accepted returns, then one commit cycle
  bit          m_act = 0, m_cmt = 0, m_d = 0;
  logic [15:0] m_base = '0;
  int          m_iss = 0, m_ret = 0;
`ifdef CACHE_ARB_RR_EN
  bit          m_last_d = 0;
`endif

  int          obs_cmt_cyc = -1, obs_iss_cyc = -1, obs_fills = 0, obs_valids = 0, obs_commits = 0;
  logic [15:0] obs_cmt_addr = '0, obs_iss_addr = '0;
  logic        obs_cmt_d = 1'b0, prev_mem_en = 1'b0;

  typedef struct {
    logic im; logic [15:0] ia; logic dm; logic [15:0] da; logic exp_d; logic [15:0] exp_base;
  } vec_t;
  vec_t vecs[5];

  int p_t0, p_cmt1, p_iss2, p_ncmt;
  logic p_first_d, p_second_d;

  function automatic logic [53:0] outs();
    return {bus.mem_en, bus.mem_addr, bus.fill_op, bus.fill_addr, bus.fill_data,
            bus.icache_fill_en, bus.dcache_fill_en, bus.busy};
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic chk_outs(input string name, input logic [53:0] exp);
    logic [53:0] got;
    got = outs();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: outputs {en,maddr,op,faddr,fdata,ien,den,busy} got %h expected %h",
               name, got, exp);
    end
  endtask

  task automatic check_cycle();
    logic        e_en, e_ien, e_den, e_busy;
    logic [15:0] e_maddr, e_faddr, e_fdata;
    logic [1:0]  e_op;
    e_en = 0; e_ien = 0; e_den = 0; e_busy = 0;
    e_maddr = '0; e_faddr = '0; e_fdata = '0; e_op = 2'b00;
    if (!rst) begin
      m_act = 0; m_cmt = 0; m_d = 0;
`ifdef CACHE_ARB_RR_EN
      m_last_d = 0;
`endif
    end else if (m_cmt) begin
      e_busy = 1; e_op = 2'b10; e_faddr = m_base; e_ien = !m_d; e_den = m_d;
      m_cmt = 0;
    end else if (m_act) begin
      e_busy = 1;
      if (m_iss < 8) begin
        e_en = 1; e_maddr = m_base + 16'(2 * m_iss);
      end
      if (bus.mem_data_valid && m_ret < 8) begin
        e_op = 2'b01; e_faddr = m_base + 16'(2 * m_ret); e_fdata = bus.mem_data;
        e_ien = !m_d; e_den = m_d;
        m_ret++;
      end
      if (m_iss < 8) m_iss++;
      if (m_iss == 8 && m_ret == 8) begin
        m_act = 0; m_cmt = 1;
      end
    end else if (bus.dcache_miss || bus.icache_miss) begin
      if (bus.dcache_miss && bus.icache_miss) begin
`ifdef CACHE_ARB_RR_EN
        m_d = !m_last_d; m_last_d = m_d;
`else
        m_d = 1;
`endif
      end else begin
        m_d = bus.dcache_miss;
      end
      m_base = (m_d ? bus.dcache_addr : bus.icache_addr) & 16'hFFF0;
      m_act = 1; m_iss = 0; m_ret = 0;
    end
    chk_outs($sformatf("cycle %0d", cyc),
             {e_en, e_maddr, e_op, e_faddr, e_fdata, e_ien, e_den, e_busy});

    if (bus.fill_op == 2'b10) begin
      obs_cmt_cyc = cyc; obs_cmt_addr = bus.fill_addr; obs_cmt_d = bus.dcache_fill_en;
      obs_commits++;
    end
    if (bus.fill_op == 2'b01) obs_fills++;
    if (bus.mem_data_valid) obs_valids++;
    if (bus.mem_en && !prev_mem_en) begin
      obs_iss_cyc = cyc; obs_iss_addr = bus.mem_addr;
    end
    prev_mem_en = bus.mem_en;
  endtask

  task automatic mem_drive();
    bit   ret;
    req_t r;
    ret = 0;
    if (bus.mem_en) memq.push_back('{bus.mem_addr, cyc + MEM_LAT});
    if (memq.size() > 0 && memq[0].ready <= cyc && ret_budget != 0) begin
      if (gap_mode) begin
        ret = (gap_pat[gap_idx % 5] != 0); gap_idx++;
      end else if (rand_gap) ret = ($urandom % 4) != 0;
      else ret = 1;
    end
    if (ret) begin
      r = memq.pop_front();
      bus.mem_data_valid = 1'b1;
      bus.mem_data = r.addr ^ 16'h5A5A;
      if (ret_budget > 0) ret_budget--;
    end else if (stale_force || (stale_rand && !m_act && ($urandom % 5) == 0)) begin
      bus.mem_data_valid = 1'b1;
      bus.mem_data = 16'($urandom);
    end else begin
      bus.mem_data_valid = 1'b0;
      bus.mem_data = 16'($urandom);
    end
  endtask

  task automatic step();
    #1;
    check_cycle();
    @(posedge clk);
    #1;
    cyc++;
    mem_drive();
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 60 && bus.busy; k++) step();
    chk("reach idle", int'(bus.busy), 0);
  endtask

  task automatic run_pair(input logic [15:0] da, input logic [15:0] ia);
    bus.dcache_miss = 1; bus.dcache_addr = da;
    bus.icache_miss = 1; bus.icache_addr = ia;
    p_t0 = cyc; p_ncmt = 0; p_cmt1 = -1; p_first_d = 0; p_second_d = 0;
    for (int k = 0; k < 80 && p_ncmt < 2; k++) begin
      obs_cmt_cyc = -1;
      step();
      if (obs_cmt_cyc >= 0) begin
        if (p_ncmt == 0) begin
          p_first_d = obs_cmt_d; p_cmt1 = obs_cmt_cyc;
        end else p_second_d = obs_cmt_d;
        p_ncmt++;
        if (obs_cmt_d) bus.dcache_miss = 0; else bus.icache_miss = 0;
      end
    end
    p_iss2 = obs_iss_cyc;
    bus.dcache_miss = 0; bus.icache_miss = 0;
  endtask

  initial begin
    int t0;
    vecs[0] = '{1'b1, 16'h1234, 1'b0, 16'h0000, 1'b0, 16'h1230};
    vecs[1] = '{1'b0, 16'h0000, 1'b1, 16'h0047, 1'b1, 16'h0040};
    vecs[2] = '{1'b1, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 16'hFFF0};
    vecs[3] = '{1'b1, 16'h8000, 1'b1, 16'h0040, 1'b1, 16'h0040};
    vecs[4] = '{1'b0, 16'h0000, 1'b1, 16'h000F, 1'b1, 16'h0000};

    bus.icache_miss = 0; bus.icache_addr = '0; bus.dcache_miss = 0; bus.dcache_addr = '0;
    bus.mem_data_valid = 0; bus.mem_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_outs("reset outputs", '0);
    rst = 1;

    // simultaneous misses held until served: D first, I starts right after D's idle cycle
    run_pair(16'h0040, 16'h8000);
    chk("pair1 commits", p_ncmt, 2);
    chk("pair1 first grant D", int'(p_first_d), 1);
    chk("pair1 second grant D", int'(p_second_d), 0);
    chk("pair1 D commit cycle", p_cmt1, p_t0 + 9 + MEM_LAT);
    chk("pair1 I first issue", p_iss2, p_t0 + 11 + MEM_LAT);
    run_pair(16'h0100, 16'h0200);
    chk("pair2 commits", p_ncmt, 2);
`ifdef CACHE_ARB_RR_EN
    chk("pair2 first grant D", int'(p_first_d), 0);
    chk("pair2 second grant D", int'(p_second_d), 1);
`else
    chk("pair2 first grant D", int'(p_first_d), 1);
    chk("pair2 second grant D", int'(p_second_d), 0);
`endif

    // table vectors: one-cycle miss pulses (requester drops mid-fill), gap-free memory
    for (int i = 0; i < 5; i++) begin
      wait_idle();
      obs_cmt_cyc = -1; obs_iss_cyc = -1;
      bus.icache_miss = vecs[i].im; bus.icache_addr = vecs[i].ia;
      bus.dcache_miss = vecs[i].dm; bus.dcache_addr = vecs[i].da;
      t0 = cyc;
      step();
      bus.icache_miss = 0; bus.dcache_miss = 0;
      for (int k = 0; k < 40 && obs_cmt_cyc < 0; k++) step();
      chk($sformatf("vec%0d commit cycle", i), obs_cmt_cyc, t0 + 9 + MEM_LAT);
      chk($sformatf("vec%0d commit addr", i), int'(obs_cmt_addr), int'(vecs[i].exp_base));
      chk($sformatf("vec%0d grant D", i), int'(obs_cmt_d), int'(vecs[i].exp_d));
      chk($sformatf("vec%0d first issue cycle", i), obs_iss_cyc, t0 + 1);
      chk($sformatf("vec%0d first issue addr", i), int'(obs_iss_addr), int'(vecs[i].exp_base));
    end

    // stale returns while idle
    wait_idle();
    stale_force = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stale fill_op", int'(bus.fill_op), 0);
      chk("stale mem_en", int'(bus.mem_en), 0);
      chk("stale busy", int'(bus.busy), 0);
    end
    stale_force = 0;

    // returns with gaps 1,0,1,1,0,...
    wait_idle();
    gap_mode = 1; gap_idx = 0; obs_fills = 0; obs_cmt_cyc = -1;
    bus.icache_miss = 1; bus.icache_addr = 16'h2468;
    step();
    bus.icache_miss = 0;
    for (int k = 0; k < 60 && obs_cmt_cyc < 0; k++) step();
    chk("gap fills", obs_fills, 8);
    chk("gap commit addr", int'(obs_cmt_addr), 16'h2460);
    gap_mode = 0;

    // reset in DRAIN after 3 returns; remaining 5 returns arrive after release
    wait_idle();
    ret_budget = 3;
    bus.dcache_miss = 1; bus.dcache_addr = 16'h3000;
    step();
    bus.dcache_miss = 0;
    for (int k = 0; k < 9; k++) step();
    chk("pre-reset fills in DRAIN", int'(bus.mem_en == 0 && bus.busy == 1), 1);
    rst = 0;
    #1;
    chk_outs("async reset outputs", '0);
    step();
    step();
    rst = 1;
    ret_budget = -1; obs_fills = 0; obs_valids = 0; obs_commits = 0;
    for (int k = 0; k < 12; k++) step();
    chk("late returns seen", obs_valids, 5);
    chk("late returns fills", obs_fills, 0);
    chk("late returns commits", obs_commits, 0);

    // randomized traffic against the model
    rand_gap = 1; stale_rand = 1; obs_commits = 0;
    for (int k = 0; k < 1500; k++) begin
      if (($urandom % 4) == 0) begin
        bus.icache_miss = 1'($urandom_range(0, 1)); bus.icache_addr = 16'($urandom);
        bus.dcache_miss = 1'($urandom_range(0, 1)); bus.dcache_addr = 16'($urandom);
      end
      step();
    end
    bus.icache_miss = 0; bus.dcache_miss = 0;
    wait_idle();
    chk("random commits occurred", int'(obs_commits > 10), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
